ahb_mem_slave: RTL and testbench



---
 rtl/ahb_pkg.sv | 37 +++
 rtl/ahb_mem_array.sv | 28 ++
 rtl/ahb_mem_slave.sv | 115 +++++++++++
 tb/tb_ahb_mem_slave.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB codes, slave state encoding and byte-lane decode for the bus fabric.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } slave_state_e;

   // Little-endian lane enables; illegal sizes enable nothing.
   function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] ofs);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << ofs;
         HSIZE_HALF: be = ofs[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: be = 4'b1111;
         default:    be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// 32-bit word array: synchronous byte-enable write, asynchronous read, no reset.
module ahb_mem_array #(
   parameter int AW = 8
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   localparam int DEPTH = 1 << AW;

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_mem_slave.sv
// Memory-backed AHB slave with configurable wait states and two-cycle ERROR response.
module ahb_mem_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic         hclk,
   input  logic         hreset_n,
   input  logic         hsel,
   input  logic [31:0]  haddr,
   input  logic [1:0]   htrans,
   input  logic         hwrite,
   input  logic [2:0]   hsize,
   input  logic [2:0]   hburst,
   input  logic [3:0]   hprot,
   input  logic         hmastlock,
   input  logic [31:0]  hwdata,
   input  logic         hready,
   output logic         hreadyout,
   output logic [1:0]   hresp,
   output logic [31:0]  hrdata,
   output logic [15:0]  hsplit,
   output slave_state_e dbg_state_o
);

   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   slave_state_e          state_q, state_d;
   logic [3:0]            wcnt_q, wcnt_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  write_q;
   logic [2:0]            size_q;
   logic                  hreadyout_q;
   logic [1:0]            hresp_q;

   logic        take;
   logic        illegal;
   logic        we;
   logic [31:0] rdata;
   logic        unused_ok;

   assign unused_ok = ^{hburst, hprot, hmastlock, haddr[31:ADDR_WIDTH]};

   // New address phases are only taken while this slave is not stretching a data phase.
   assign take = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)
                 && (state_q != ST_WAIT) && (state_q != ST_ERR1);

   assign illegal = (hsize > HSIZE_WORD)
                 || (hsize == HSIZE_HALF && haddr[0])
                 || (hsize == HSIZE_WORD && haddr[1:0] != 2'b00);

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         ST_WAIT: begin
            if (wcnt_q == 4'd0) state_d = ST_DATA;
            else                wcnt_d  = wcnt_q - 4'd1;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            if (!take)                state_d = ST_IDLE;
            else if (illegal)         state_d = ST_ERR1;
            else if (WAIT_STATES > 0) begin
               state_d = ST_WAIT;
               wcnt_d  = WAIT_LOAD;
            end
            else                      state_d = ST_DATA;
         end
      endcase
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q     <= ST_IDLE;
         wcnt_q      <= 4'd0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         size_q      <= 3'd0;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         hreadyout_q <= !(state_d == ST_WAIT || state_d == ST_ERR1);
         hresp_q     <= (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
         if (take) begin
            addr_q  <= haddr[ADDR_WIDTH-1:0];
            write_q <= hwrite;
            size_q  <= hsize;
         end
      end
   end

   // ST_DATA is only reachable for legal transfers, so the write needs no extra qualifier.
   assign we = (state_q == ST_DATA) && write_q;

   ahb_mem_array #(.AW(ADDR_WIDTH - 2)) u_mem (
      .clk_i   (hclk),
      .we_i    (we),
      .be_i    (byte_en(size_q, addr_q[1:0])),
      .waddr_i (addr_q[ADDR_WIDTH-1:2]),
      .wdata_i (hwdata),
      .raddr_i (addr_q[ADDR_WIDTH-1:2]),
      .rdata_o (rdata)
   );

   assign hreadyout   = hreadyout_q;
   assign hresp       = hresp_q;
   assign hrdata      = (state_q == ST_DATA && !write_q) ? rdata : 32'd0;
   assign hsplit      = 16'd0;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: two instances (1 and 3 wait states) behind a tiny slave mux.
module tb_ahb_mem_slave;
   import ahb_pkg::*;

   localparam int AW  = 10;
   localparam int WS0 = 1;
   localparam int WS1 = 3;

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   logic         hclk = 1'b0;
   logic         hreset_n;
   logic         bsel;
   logic [31:0]  haddr;
   logic [1:0]   htrans;
   logic         hwrite;
   logic [2:0]   hsize;
   logic [31:0]  hwdata;
   logic         stall;
   logic         sel_dut;
   logic         hsel0, hsel1, hready;
   logic         ro0, ro1;
   logic [1:0]   resp0, resp1;
   logic [31:0]  rdata0, rdata1;
   logic [15:0]  split0, split1;
   slave_state_e st0, st1;

   int           n_checks = 0;
   int           n_errors = 0;
   xfer_t        pend_q[$];
   logic [31:0]  mem_m[int];
   logic [31:0]  last_rdata;
   logic         stall_en = 1'b0;

   // ---------------- clock / reset / fabric ----------------
   always #5 hclk = ~hclk;

   assign hsel0  = bsel && !sel_dut;
   assign hsel1  = bsel && sel_dut;
   assign hready = stall ? 1'b0 : (sel_dut ? ro1 : ro0);

   ahb_mem_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS0)) dut0 (
      .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'd0), .hmastlock(1'b0),
      .hwdata(hwdata), .hready(hready), .hreadyout(ro0), .hresp(resp0), .hrdata(rdata0),
      .hsplit(split0), .dbg_state_o(st0)
   );

   ahb_mem_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS1)) dut1 (
      .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(3'd1), .hprot(4'd3), .hmastlock(1'b0),
      .hwdata(hwdata), .hready(hready), .hreadyout(ro1), .hresp(resp1), .hrdata(rdata1),
      .hsplit(split1), .dbg_state_o(st1)
   );

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit is_illegal(input xfer_t x);
      return (x.size > 3'd2) || ((x.addr % (32'd1 << x.size)) != 0);
   endfunction

   function automatic int mkey(input logic s, input logic [31:0] a);
      return (s ? 4096 : 0) + int'(a[AW-1:2]);
   endfunction

   function automatic logic [31:0] model_rd(input logic s, input logic [31:0] a);
      int k = mkey(s, a);
      return mem_m.exists(k) ? mem_m[k] : 32'd0;
   endfunction

   task automatic model_wr(input logic s, input xfer_t x);
      int k = mkey(s, x.addr);
      int lane;
      logic [31:0] w = model_rd(s, x.addr);
      for (int b = 0; b < (1 << x.size); b++) begin
         lane = int'(x.addr % 4) + b;
         w[8*lane +: 8] = x.wdata[8*lane +: 8];
      end
      mem_m[k] = w;
   endtask

   // ---------------- driver ----------------
   function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                                input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata);
      xfer_t x;
      x.sel = sel; x.trans = trans; x.wr = wr; x.size = size; x.addr = addr; x.wdata = wdata;
      return x;
   endfunction

   task automatic push(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
      pend_q.push_back(mk(1'b1, trans, wr, size, addr, wdata));
   endtask

   task automatic drive(input xfer_t x);
      bsel   = x.sel;
      htrans = x.trans;
      hwrite = x.wr;
      hsize  = x.size;
      haddr  = x.addr;
   endtask

   // Plays pend_q onto one slave, pipelined, checking every cycle against the model.
   task automatic run_xfers(input logic s);
      xfer_t dp, acc_x, x;
      bit    dp_valid = 0, acc = 0, end_cyc, last;
      int    cyc = 0, len = 1, guard = 0;
      int    ws = s ? WS1 : WS0;
      logic        ro;
      logic [1:0]  rs;
      logic [31:0] rd, exp_rd;
      slave_state_e st;
      sel_dut = s;
      while (guard < 5000) begin
         guard++;
         @(negedge hclk);
         if (acc) begin
            dp = acc_x; dp_valid = 1; cyc = 0;
         end
         acc = 0;
         hwdata = (dp_valid && dp.wr) ? dp.wdata : $urandom();
         ro = s ? ro1 : ro0;
         rs = s ? resp1 : resp0;
         rd = s ? rdata1 : rdata0;
         st = s ? st1 : st0;
         if (dp_valid) begin
            cyc++;
            if (is_illegal(dp)) begin
               len = 2;
               chk("err_ready", {31'd0, ro}, {31'd0, cyc == 2});
               chk("err_resp", {30'd0, rs}, {30'd0, HRESP_ERROR});
               chk("err_rdata", rd, 32'd0);
            end else begin
               len  = ws + 1;
               last = (cyc == len);
               exp_rd = (last && !dp.wr) ? model_rd(s, dp.addr) : 32'd0;
               chk("ok_ready", {31'd0, ro}, {31'd0, last});
               chk("ok_resp", {30'd0, rs}, {30'd0, HRESP_OKAY});
               chk("ok_rdata", rd, exp_rd);
               if (last && !dp.wr) last_rdata = rd;
            end
         end else begin
            chk("idle_ready", {31'd0, ro}, 32'd1);
            chk("idle_resp", {30'd0, rs}, 32'd0);
            chk("idle_rdata", rd, 32'd0);
            chk("idle_state", 32'(st), 32'(ST_IDLE));
            chk("hsplit", {16'd0, s ? split1 : split0}, 32'd0);
         end
         end_cyc = !dp_valid || (cyc == len);
         stall = !dp_valid && stall_en && ($urandom_range(0, 4) == 0);
         if (dp_valid && end_cyc) begin
            if (!is_illegal(dp) && dp.wr) model_wr(s, dp);
            dp_valid = 0;
         end
         if (end_cyc) begin
            x = (pend_q.size() > 0) ? pend_q[0] : mk(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'd0, 32'd0);
            drive(x);
            if (!stall) begin
               if (pend_q.size() > 0) void'(pend_q.pop_front());
               acc   = x.sel && x.trans[1];
               acc_x = x;
            end
         end
         if (pend_q.size() == 0 && !dp_valid && !acc && !stall) break;
      end
      stall = 1'b0;
      chk("run_timeout", {31'd0, guard >= 5000}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      hreset_n = 1'b0;
      stall    = 1'b0;
      sel_dut  = 1'b0;
      hwdata   = 32'd0;
      last_rdata = 32'd0;
      drive(mk(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'd0, 32'd0));
      repeat (3) @(negedge hclk);
      chk("rst_ready0", {31'd0, ro0}, 32'd1);
      chk("rst_ready1", {31'd0, ro1}, 32'd1);
      chk("rst_resp", {28'd0, resp0, resp1}, 32'd0);
      chk("rst_rdata", rdata0 | rdata1, 32'd0);
      chk("rst_split", {split0, split1}, 32'd0);
      chk("rst_state", 32'(st0), 32'(ST_IDLE));
      hreset_n = 1'b1;

      // IDLE and BUSY with hsel=1 are never accepted
      push(HTRANS_IDLE, 1'b1, HSIZE_WORD, 32'h10, 32'hFFFF_FFFF);
      push(HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h14, 32'hFFFF_FFFF);
      run_xfers(1'b0);

      // preload 32 words in each slave
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 32; i++)
            push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'(i * 4), (s != 0 ? 32'h5A00_0000 : 32'hA500_0000) + 32'(i));
         run_xfers(s[0]);
      end

      // back-to-back write then read of the same word
      push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'hDEAD_BEEF);
      push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'd0);
      run_xfers(1'b0);
      chk("raw_rdata", last_rdata, 32'hDEAD_BEEF);

      // byte and halfword merges
      push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h1122_3344);
      push(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h21, 32'hAAAA_AAAA);
      push(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h22, 32'h5566_5566);
      push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'd0);
      run_xfers(1'b0);
      chk("merge_rdata", last_rdata, 32'h5566_AA44);

      // misaligned word and oversize transfer give ERROR and leave the array alone
      push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h02, 32'd0);
      push(HTRANS_NONSEQ, 1'b1, 3'd3, 32'h00, 32'hFFFF_FFFF);
      push(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h01, 32'hFFFF_FFFF);
      push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h00, 32'd0);
      run_xfers(1'b0);
      chk("err_nowrite", last_rdata, 32'hA500_0000);

      // BUSY inside a SEQ burst on the 3-wait-state slave
      push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40, 32'd0);
      push(HTRANS_SEQ,    1'b0, HSIZE_WORD, 32'h44, 32'd0);
      push(HTRANS_BUSY,   1'b0, HSIZE_WORD, 32'h48, 32'd0);
      push(HTRANS_SEQ,    1'b0, HSIZE_WORD, 32'h48, 32'd0);
      run_xfers(1'b1);
      chk("burst_rdata", last_rdata, 32'h5A00_0012);

      // reset in the 2nd wait cycle of a write aborts it
      push(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30, 32'd0);
      run_xfers(1'b1);
      sel_dut = 1'b1;
      @(negedge hclk);
      drive(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30, 32'd0));
      @(negedge hclk);
      drive(mk(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'd0, 32'd0));
      hwdata = 32'h1234_5678;
      chk("rst_wait1_ready", {31'd0, ro1}, 32'd0);
      @(negedge hclk);
      chk("rst_wait2_state", 32'(st1), 32'(ST_WAIT));
      hreset_n = 1'b0;
      #1;
      chk("async_ready", {31'd0, ro1}, 32'd1);
      chk("async_resp", {30'd0, resp1}, 32'd0);
      chk("async_rdata", rdata1, 32'd0);
      chk("async_state", 32'(st1), 32'(ST_IDLE));
      @(negedge hclk);
      hreset_n = 1'b1;
      push(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30, 32'd0);
      run_xfers(1'b1);
      chk("abort_nowrite", last_rdata, 32'd0);

      // randomized traffic with other-slave stalls
      stall_en = 1'b1;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 80; i++) begin
            pend_q.push_back(mk($urandom_range(0, 9) != 0,
                                2'($urandom_range(0, 3)),
                                1'($urandom_range(0, 1)),
                                ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2)),
                                32'($urandom_range(0, 127)),
                                $urandom()));
         end
         run_xfers(s[0]);
      end
      stall_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
